tc_sram_latch_mp: RTL and testbench
===================================

TC_SRAM_LATCH_MP -- requirements
Module: tc_sram_latch_mp

Interface
REQ-001 SHALL have parameter NumWords, default 32'd1024: number of words in the data array, at least 2.
REQ-002 SHALL have parameter DataWidth, default 32'd128: word width in bits.
REQ-003 SHALL have parameter ByteWidth, default 32'd8: width of one byte lane.
REQ-004 SHALL have parameter NumPorts, default 32'd2: number of identical read/write ports, 1 to 8.
REQ-005 SHALL have parameter Latency, default 32'd1: read latency in cycles, 1 to 3.
REQ-006 SHALL have dependent parameters AddrWidth = $clog2(NumWords) and BeWidth = ceil(DataWidth/ByteWidth), which are never overridden.
REQ-007 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-009 SHALL have port req_i, input, [NumPorts]: per-port request.
REQ-010 SHALL have port we_i, input, [NumPorts]: per-port write enable, qualified by req_i.
REQ-011 SHALL have port addr_i, input, [NumPorts][AddrWidth]: per-port word address.
REQ-012 SHALL have port wdata_i, input, [NumPorts][DataWidth]: per-port write data.
REQ-013 SHALL have port be_i, input, [NumPorts][BeWidth]: per-port byte enable, honoured on writes only.
REQ-014 SHALL have port rdata_o, output, [NumPorts][DataWidth]: per-port read data.
REQ-015 SHALL have port rvalid_o, output, [NumPorts]: per-port read-data-valid strobe.

Function
REQ-016 A write SHALL occur when req_i[p]=1 and we_i[p]=1; at that edge it updates only the byte lanes whose be_i[p] bit is set.
REQ-017 The last lane, when DataWidth is not a multiple of ByteWidth, SHALL be partial and controlled by the MSB of be_i.
REQ-018 A read SHALL occur when req_i[p]=1 and we_i[p]=0; it samples addr_i[p] at the edge.
REQ-019 Read data SHALL appear on rdata_o[p], with rvalid_o[p]=1 for exactly one cycle, exactly Latency cycles after the request edge.
REQ-020 Reads SHALL be fully pipelined: one new read per port per cycle, with back-to-back reads producing back-to-back rvalid_o.
REQ-021 rdata_o[p] SHALL hold the last returned value until the next read on that port returns; it SHALL NOT change on writes.
REQ-022 Read-during-write to the same address in the same cycle, from the same port or another port, SHALL return the old data.
REQ-023 On a write collision (several ports write the same address in one cycle), each byte lane SHALL take the value from the highest-index port enabling that lane; the lanes are resolved independently.
REQ-024 Any address >= NumWords (non-power-of-two NumWords) SHALL be ignored on writes and SHALL return all-zero data with rvalid_o asserted on reads.
REQ-025 A write with be_i all zero SHALL leave memory unchanged.
REQ-026 A write SHALL produce no rvalid_o pulse.
REQ-027 req_i[p]=0 SHALL leave all state for port p unchanged, apart from the read pipeline advancing.
REQ-028 The storage SHALL be a per-word, per-lane clock-gated register/latch array written through a single write-decode stage, with no read-port multiplexing on the write path.

Reset
REQ-029 While rst_ni=0 at a clock edge, the block SHALL clear all memory words to zero.
REQ-030 While rst_ni=0 at a clock edge, the block SHALL clear rdata_o to zero and rvalid_o to zero, and flush all in-flight reads.
REQ-031 While rst_ni=0, requests SHALL be ignored.
REQ-032 When reset is asserted mid-operation, reads issued up to Latency-1 cycles earlier SHALL produce no rvalid_o.
REQ-033 The first request SHALL be accepted at the first edge with rst_ni=1.

Verification
REQ-034 Latency=2, NumPorts=2: port0 writes addr 5 = 0xDEAD_BEEF with be all ones; port1 reads addr 5 in the next cycle -> port1 rvalid_o=1 two cycles after the read with rdata_o=0xDEAD_BEEF (lower 32 bits), while rdata_o[0] stays 0.
REQ-035 Same cycle: port0 writes addr 3 = 0x1111 and port1 reads addr 3, which holds 0x0 after reset -> port1 returns 0x0; a following read returns 0x1111.
REQ-036 Collision at addr 7: port0 writes 0xAAAA with be=2'b11 and port1 writes 0xBBBB with be=2'b01 (16-bit data) -> a read of addr 7 returns 0xAABB.
REQ-037 Latency=3, reads issued on 4 consecutive cycles to addrs 0..3, which were preloaded with 0x10..0x13 -> rvalid_o high for 4 consecutive cycles starting 3 cycles later, returning 0x10, 0x11, 0x12, 0x13 in order.
REQ-038 A read issued, then rst_ni=0 one cycle later -> no rvalid_o pulse, rdata_o=0, and all words read 0 after reset is released.
REQ-039 NumWords=24: a write to addr 25 and then a read of addr 25 -> rvalid_o=1 with rdata_o=0, and addr 1 is unchanged (no aliasing).

Source files
------------

// File: rtl/tc_sram_latch_mp.sv
// Multi-port SRAM model built from a per-word, per-lane enabled register array.
// Writes pass through one shared decode stage that resolves byte-lane
// collisions by port index; reads sample the array at the request edge and
// travel down a Latency-deep valid/data pipeline.
module tc_sram_latch_mp #(
  parameter int unsigned NumWords  = 32'd1024,
  parameter int unsigned DataWidth = 32'd128,
  parameter int unsigned ByteWidth = 32'd8,
  parameter int unsigned NumPorts  = 32'd2,
  parameter int unsigned Latency   = 32'd1,
  parameter int unsigned AddrWidth = (NumWords > 32'd1) ? $clog2(NumWords) : 32'd1,
  parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 32'd1) / ByteWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumPorts-1:0]                 req_i,
  input  logic [NumPorts-1:0]                 we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
  output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o,
  output logic [NumPorts-1:0]                 rvalid_o
);

  // Storage array
  logic [DataWidth-1:0] mem_q [NumWords];

  // Write decode results: per-word lane enables (the gating condition for each
  // word/lane cell group), merged write data and the bit-expanded lane mask.
  logic [BeWidth-1:0]   wr_lane_en  [NumWords];
  logic [DataWidth-1:0] wr_word     [NumWords];
  logic [DataWidth-1:0] wr_bit_mask [NumWords];

  // Read side
  logic [NumPorts-1:0]  rd_req;
  logic [DataWidth-1:0] rd_word [NumPorts];

  // Read pipeline: stage 0 is loaded at the request edge, stage Latency-1 drives the outputs
  logic [Latency-1:0]   vld_q [NumPorts];
  logic [DataWidth-1:0] dat_q [NumPorts][Latency];

  // Write decode: ports are scanned in ascending order so the highest-index
  // port enabling a lane wins that lane; lanes resolve independently.
  always_comb begin
    for (int w = 0; w < NumWords; w++) begin
      wr_lane_en[w]  = '0;
      wr_word[w]     = '0;
      wr_bit_mask[w] = '0;
      for (int p = 0; p < NumPorts; p++) begin
        if (req_i[p] && we_i[p] && (addr_i[p] == AddrWidth'(w))) begin
          wr_lane_en[w] = wr_lane_en[w] | be_i[p];
          for (int i = 0; i < DataWidth; i++) begin
            if (be_i[p][i / ByteWidth]) begin
              wr_word[w][i] = wdata_i[p][i];
            end
          end
        end
      end
      // A partial top lane falls out naturally: its bits map to the MSB of be.
      for (int i = 0; i < DataWidth; i++) begin
        wr_bit_mask[w][i] = wr_lane_en[w][i / ByteWidth];
      end
    end
  end

  // Array update: only cells whose lane enable is set are loaded; reset clears every word
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int w = 0; w < NumWords; w++) begin
        mem_q[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NumWords; w++) begin
        if (|wr_lane_en[w]) begin
          mem_q[w] <= (mem_q[w] & ~wr_bit_mask[w]) | (wr_word[w] & wr_bit_mask[w]);
        end
      end
    end
  end

  // Read select: samples the pre-write array contents, so a same-edge write is
  // invisible; out-of-range addresses return zero.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      rd_req[p]  = req_i[p] & ~we_i[p];
      rd_word[p] = '0;
      if (32'(addr_i[p]) < NumWords) begin
        rd_word[p] = mem_q[addr_i[p]];
      end
    end
  end

  // Read pipeline: data stages only load on a valid, so the last stage holds
  // the most recently returned word between reads.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int p = 0; p < NumPorts; p++) begin
        vld_q[p] <= '0;
        for (int s = 0; s < Latency; s++) begin
          dat_q[p][s] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        vld_q[p][0] <= rd_req[p];
        if (rd_req[p]) begin
          dat_q[p][0] <= rd_word[p];
        end
        for (int s = 1; s < Latency; s++) begin
          vld_q[p][s] <= vld_q[p][s-1];
          if (vld_q[p][s-1]) begin
            dat_q[p][s] <= dat_q[p][s-1];
          end
        end
      end
    end
  end

  // Output mapping from the final pipeline stage
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      rvalid_o[p] = vld_q[p][Latency-1];
      rdata_o[p]  = dat_q[p][Latency-1];
    end
  end

endmodule

// File: tb/tb_tc_sram_latch_mp.sv
// Directed bench for tc_sram_latch_mp using three configurations:
//   A: 16 words x 32 bit, 2 ports, latency 2
//   B: 24 words x 16 bit, 2 ports, latency 3 (non-power-of-two depth)
//   C: 4 words x 12 bit, 1 port, latency 1 (partial top lane)
module tb_tc_sram_latch_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  logic [1:0]       a_req, a_we, a_rvalid;
  logic [1:0][3:0]  a_addr, a_be;
  logic [1:0][31:0] a_wdata, a_rdata;

  logic [1:0]       b_req, b_we, b_rvalid;
  logic [1:0][4:0]  b_addr;
  logic [1:0][1:0]  b_be;
  logic [1:0][15:0] b_wdata, b_rdata;

  logic [0:0]       c_req, c_we, c_rvalid;
  logic [0:0][1:0]  c_addr, c_be;
  logic [0:0][11:0] c_wdata, c_rdata;

  tc_sram_latch_mp #(.NumWords(16), .DataWidth(32), .ByteWidth(8), .NumPorts(2), .Latency(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .we_i(a_we), .addr_i(a_addr),
    .wdata_i(a_wdata), .be_i(a_be), .rdata_o(a_rdata), .rvalid_o(a_rvalid));

  tc_sram_latch_mp #(.NumWords(24), .DataWidth(16), .ByteWidth(8), .NumPorts(2), .Latency(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .we_i(b_we), .addr_i(b_addr),
    .wdata_i(b_wdata), .be_i(b_be), .rdata_o(b_rdata), .rvalid_o(b_rvalid));

  tc_sram_latch_mp #(.NumWords(4), .DataWidth(12), .ByteWidth(8), .NumPorts(1), .Latency(1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(c_req), .we_i(c_we), .addr_i(c_addr),
    .wdata_i(c_wdata), .be_i(c_be), .rdata_o(c_rdata), .rvalid_o(c_rvalid));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_idle();
    a_req = '0; a_we = '0;
  endtask

  task automatic a_wr(input logic p, input int addr, input logic [31:0] d, input logic [3:0] be);
    a_req[p] = 1'b1; a_we[p] = 1'b1; a_addr[p] = 4'(addr); a_wdata[p] = d; a_be[p] = be;
  endtask

  task automatic a_rd(input logic p, input int addr);
    a_req[p] = 1'b1; a_we[p] = 1'b0; a_addr[p] = 4'(addr); a_be[p] = 4'hF;
  endtask

  task automatic b_idle();
    b_req = '0; b_we = '0;
  endtask

  task automatic b_wr(input logic p, input int addr, input logic [15:0] d, input logic [1:0] be);
    b_req[p] = 1'b1; b_we[p] = 1'b1; b_addr[p] = 5'(addr); b_wdata[p] = d; b_be[p] = be;
  endtask

  task automatic b_rd(input logic p, input int addr);
    b_req[p] = 1'b1; b_we[p] = 1'b0; b_addr[p] = 5'(addr); b_be[p] = 2'b11;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_be = '0;
    c_req = '0; c_we = '0; c_addr = '0; c_wdata = '0; c_be = '0;

    // ---------------- A: reset, read-during-write, byte enables, flush
    rst_n = 1'b0;
    a_wr(1'b0, 3, 32'hFFFF_FFFF, 4'hF);
    a_rd(1'b1, 3);
    repeat (3) step();
    chk("a_rst_rvalid", 64'(a_rvalid), 64'h0);
    chk("a_rst_rdata1", 64'(a_rdata[1]), 64'h0);

    a_idle(); rst_n = 1'b1;
    a_wr(1'b0, 3, 32'h0000_1111, 4'hF); a_rd(1'b1, 3);
    step();
    chk("a_first_rvalid", 64'(a_rvalid), 64'h0);

    a_idle(); a_rd(1'b1, 3);
    step();
    chk("a_rdw_rvalid", 64'(a_rvalid), 64'h2);
    chk("a_rdw_old", 64'(a_rdata[1]), 64'h0);

    a_idle(); a_wr(1'b0, 5, 32'hDEAD_BEEF, 4'hF);
    step();
    chk("a_rd_new_rvalid", 64'(a_rvalid), 64'h2);
    chk("a_rd_new", 64'(a_rdata[1]), 64'h1111);

    a_idle(); a_rd(1'b1, 5);
    step();
    chk("a_wr_no_rvalid", 64'(a_rvalid), 64'h0);
    chk("a_hold", 64'(a_rdata[1]), 64'h1111);

    a_idle();
    step();
    chk("a_beef_rvalid", 64'(a_rvalid), 64'h2);
    chk("a_beef", 64'(a_rdata[1]), 64'hDEAD_BEEF);
    chk("a_p0_quiet", 64'(a_rdata[0]), 64'h0);

    a_wr(1'b0, 5, 32'h1234_5678, 4'b0101);
    step();
    a_idle(); a_rd(1'b1, 5);
    step();
    a_idle();
    step();
    chk("a_be_part", 64'(a_rdata[1]), 64'hDE34_BE78);

    a_wr(1'b0, 3, 32'hFFFF_FFFF, 4'h0);
    step();
    a_idle(); a_rd(1'b1, 3);
    step();
    a_idle();
    step();
    chk("a_be_zero_rvalid", 64'(a_rvalid), 64'h2);
    chk("a_be_zero", 64'(a_rdata[1]), 64'h1111);

    a_rd(1'b1, 5);
    step();
    a_idle(); rst_n = 1'b0;
    step();
    chk("a_flush_rvalid", 64'(a_rvalid), 64'h0);
    chk("a_flush_rdata", 64'(a_rdata[1]), 64'h0);
    step();
    chk("a_flush_rvalid2", 64'(a_rvalid), 64'h0);

    rst_n = 1'b1; a_rd(1'b0, 5); a_rd(1'b1, 3);
    step();
    a_idle();
    step();
    chk("a_post_rst_rvalid", 64'(a_rvalid), 64'h3);
    chk("a_post_rst_w5", 64'(a_rdata[0]), 64'h0);
    chk("a_post_rst_w3", 64'(a_rdata[1]), 64'h0);

    // ---------------- B: preload, collision, out-of-range, pipelined reads
    b_wr(1'b0, 0, 16'h0010, 2'b11); b_wr(1'b1, 1, 16'h0011, 2'b11);
    step();
    b_wr(1'b0, 2, 16'h0012, 2'b11); b_wr(1'b1, 3, 16'h0013, 2'b11);
    step();
    b_wr(1'b0, 7, 16'hAAAA, 2'b11); b_wr(1'b1, 7, 16'hBBBB, 2'b01);
    step();
    b_idle(); b_wr(1'b0, 25, 16'hFFFF, 2'b11);
    step();

    b_idle(); b_rd(1'b0, 0); b_rd(1'b1, 7);
    step();
    chk("b_lat_0", 64'(b_rvalid), 64'h0);
    b_rd(1'b0, 1); b_rd(1'b1, 25);
    step();
    chk("b_lat_1", 64'(b_rvalid), 64'h0);
    b_rd(1'b0, 2); b_rd(1'b1, 1);
    step();
    chk("b_pipe0_rvalid", 64'(b_rvalid), 64'h3);
    chk("b_pipe0", 64'(b_rdata[0]), 64'h10);
    chk("b_collision", 64'(b_rdata[1]), 64'hAABB);
    b_idle(); b_rd(1'b0, 3);
    step();
    chk("b_pipe1_rvalid", 64'(b_rvalid), 64'h3);
    chk("b_pipe1", 64'(b_rdata[0]), 64'h11);
    chk("b_oob_zero", 64'(b_rdata[1]), 64'h0);
    b_idle();
    step();
    chk("b_pipe2_rvalid", 64'(b_rvalid), 64'h3);
    chk("b_pipe2", 64'(b_rdata[0]), 64'h12);
    chk("b_no_alias", 64'(b_rdata[1]), 64'h11);
    step();
    chk("b_pipe3_rvalid", 64'(b_rvalid), 64'h1);
    chk("b_pipe3", 64'(b_rdata[0]), 64'h13);
    chk("b_hold1", 64'(b_rdata[1]), 64'h11);
    step();
    chk("b_done_rvalid", 64'(b_rvalid), 64'h0);
    chk("b_hold0", 64'(b_rdata[0]), 64'h13);

    // ---------------- C: latency 1 and partial top lane
    c_req = 1'b1; c_we = 1'b1; c_addr[0] = 2'd2; c_wdata[0] = 12'hABC; c_be[0] = 2'b10;
    step();
    chk("c_wr_rvalid", 64'(c_rvalid), 64'h0);
    c_we = 1'b0;
    step();
    chk("c_rd_rvalid", 64'(c_rvalid), 64'h1);
    chk("c_top_lane", 64'(c_rdata[0]), 64'hA00);
    c_we = 1'b1; c_wdata[0] = 12'h5DE; c_be[0] = 2'b01;
    step();
    chk("c_wr2_rvalid", 64'(c_rvalid), 64'h0);
    chk("c_hold", 64'(c_rdata[0]), 64'hA00);
    c_we = 1'b0;
    step();
    chk("c_low_lane", 64'(c_rdata[0]), 64'hADE);
    c_req = 1'b0;
    step();
    chk("c_idle_rvalid", 64'(c_rvalid), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
